// File: rtl/user_pulser_scheduler.sv
// Schedule sequencer for the user-domain pulser array.
// Replays a small table of timed start commands (mask, delay, wait-for-ready)
// on go_i, optionally looping, and emits one-cycle start/stop strobes.
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   cfg_we_i/idx/mask/delay/wait      table write port (honoured only when idle)
//   num_entries_i, loops_i            run length and pass count, latched at go
//   go_i, abort_i                     run control
//   ready_i                           pulser IDLE/DONE flags
//   start_o, stop_o                   per-pulser one-cycle strobes
//   busy_o, done_o, cur_idx_o         run status
module user_pulser_scheduler #(
  parameter int unsigned N_PULSER_INST = 4,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned DELAY_WIDTH   = 16,
  parameter int unsigned IDX_W         = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cfg_we_i,
  input  logic [IDX_W-1:0]         cfg_idx_i,
  input  logic [N_PULSER_INST-1:0] cfg_mask_i,
  input  logic [DELAY_WIDTH-1:0]   cfg_delay_i,
  input  logic                     cfg_wait_i,
  input  logic [IDX_W:0]           num_entries_i,
  input  logic [7:0]               loops_i,
  input  logic                     go_i,
  input  logic                     abort_i,
  input  logic [N_PULSER_INST-1:0] ready_i,
  output logic [N_PULSER_INST-1:0] start_o,
  output logic [N_PULSER_INST-1:0] stop_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [IDX_W-1:0]         cur_idx_o
);

  localparam int unsigned LEN_W = IDX_W + 1;
  localparam int unsigned NP    = N_PULSER_INST;
  localparam int unsigned DW    = DELAY_WIDTH;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, DELAY, WAIT_RDY} state_t;

  // Schedule table
  logic [NP-1:0] mask_q  [DEPTH];
  logic [DW-1:0] delay_q [DEPTH];
  logic          wait_q  [DEPTH];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
  logic [DW-1:0]     cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d, len_go;
  logic [7:0]        loops_q, loops_d;
  logic [NP-1:0]     fired_q, fired_d;
  logic              blank_q, blank_d;
  logic [NP-1:0]     stop_q, stop_d;
  logic              done_q, done_d;
  logic [NP-1:0]     start_c;
  logic              adv;

  assign len_go  = (num_entries_i > DEPTH_L) ? DEPTH_L : num_entries_i;
  assign idx_nxt = idx_q + IDX_W'(1);

  // Table writes, accepted only while idle and in range
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mask_q[i]  <= '0;
        delay_q[i] <= '0;
        wait_q[i]  <= 1'b0;
      end
    end else if (cfg_we_i && (state_q == IDLE) && (LEN_W'(cfg_idx_i) < DEPTH_L)) begin
      mask_q[cfg_idx_i]  <= cfg_mask_i;
      delay_q[cfg_idx_i] <= cfg_delay_i;
      wait_q[cfg_idx_i]  <= cfg_wait_i;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      loops_q <= '0;
      fired_q <= '0;
      blank_q <= 1'b0;
      stop_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      loops_q <= loops_d;
      fired_q <= fired_d;
      blank_q <= blank_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    loops_d = loops_q;
    fired_d = fired_q;
    blank_d = 1'b0;
    stop_d  = '0;
    done_d  = 1'b0;
    start_c = '0;
    adv     = 1'b0;

    case (state_q)
      IDLE: begin
        if (go_i && (len_go != '0)) begin
          len_d   = len_go;
          loops_d = loops_i;
          idx_d   = '0;
          cnt_d   = delay_q[0];
          fired_d = '0;
          state_d = DELAY;
        end
      end
      DELAY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DW'(1);
        end else begin
          // Fire cycle: start strobe depends only on registered state
          start_c = mask_q[idx_q];
          fired_d = fired_q | mask_q[idx_q];
          if (wait_q[idx_q]) begin
            state_d = WAIT_RDY;
            blank_d = 1'b1;
          end else begin
            adv = 1'b1;
          end
        end
      end
      WAIT_RDY: begin
        // First cycle after firing is blanked so stale ready flags are ignored
        if (!blank_q && ((ready_i & mask_q[idx_q]) == mask_q[idx_q])) adv = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      if ((LEN_W'(idx_q) + LEN_W'(1)) < len_q) begin
        idx_d   = idx_nxt;
        cnt_d   = delay_q[idx_nxt];
        state_d = DELAY;
      end else if (loops_q == 8'd1) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        // loops_q == 0 means run forever
        if (loops_q != 8'd0) loops_d = loops_q - 8'd1;
        idx_d   = '0;
        cnt_d   = delay_q[0];
        state_d = DELAY;
      end
    end

    // Abort wins over any advance; stop covers a start issued this cycle
    if ((state_q != IDLE) && abort_i) begin
      state_d = IDLE;
      stop_d  = fired_d;
      done_d  = 1'b0;
    end
  end

  assign start_o   = start_c;
  assign stop_o    = stop_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign cur_idx_o = idx_q;

endmodule

// File: tb/tb_user_pulser_scheduler.sv
// Self-checking bench for user_pulser_scheduler: directed scenarios plus
// randomized runs compared against a timeline model of the schedule.
module tb_user_pulser_scheduler;

  localparam int unsigned NP    = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned IW    = 3;
  localparam int LOGN = 8192;
  localparam int LIM  = LOGN - 64;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cfg_we_i = 1'b0;
  logic [IW-1:0] cfg_idx_i = '0;
  logic [NP-1:0] cfg_mask_i = '0;
  logic [DW-1:0] cfg_delay_i = '0;
  logic          cfg_wait_i = 1'b0;
  logic [IW:0]   num_entries_i = '0;
  logic [7:0]    loops_i = '0;
  logic          go_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [NP-1:0] ready_i = '1;
  logic [NP-1:0] start_o, stop_o;
  logic          busy_o, done_o;
  logic [IW-1:0] cur_idx_o;

  user_pulser_scheduler #(
    .N_PULSER_INST(NP), .DEPTH(DEPTH), .DELAY_WIDTH(DW), .IDX_W(IW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_mask_i(cfg_mask_i),
    .cfg_delay_i(cfg_delay_i), .cfg_wait_i(cfg_wait_i),
    .num_entries_i(num_entries_i), .loops_i(loops_i),
    .go_i(go_i), .abort_i(abort_i), .ready_i(ready_i),
    .start_o(start_o), .stop_o(stop_o), .busy_o(busy_o), .done_o(done_o),
    .cur_idx_o(cur_idx_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Ready waveform indexed by absolute cycle; driven just after each edge
  logic [NP-1:0] rdy_wave [LOGN];
  always @(posedge clk_i) begin
    #1;
    if (cyc < LOGN) ready_i = rdy_wave[cyc];
  end

  // Observed outputs per cycle
  logic [NP-1:0] log_start [LOGN];
  logic [NP-1:0] log_stop  [LOGN];
  logic          log_busy  [LOGN];
  logic          log_done  [LOGN];
  always @(negedge clk_i) begin
    if (cyc < LOGN) begin
      log_start[cyc] = start_o;
      log_stop[cyc]  = stop_o;
      log_busy[cyc]  = busy_o;
      log_done[cyc]  = done_o;
    end
  end

  // Expected outputs per cycle and table mirror
  logic [NP-1:0] exp_start [LOGN];
  logic [NP-1:0] exp_stop  [LOGN];
  logic          exp_busy  [LOGN];
  logic          exp_done  [LOGN];
  logic [NP-1:0] tbl_mask  [DEPTH];
  int            tbl_delay [DEPTH];
  bit            tbl_wait  [DEPTH];

  // Timeline model: each entry fires delay+1 cycles after the previous entry
  // finished; a wait entry finishes at the first cycle >= fire+2 where all its
  // pulsers are ready. Abort truncates everything after the abort cycle.
  // Returns the cycle holding done (or stop after an abort).
  function automatic int model_run(input int t0, input int len, input int loops, input int abort_at);
    int ln, t, fire, w, pass;
    logic [NP-1:0] fired;
    for (int c = 0; c < LOGN; c++) begin
      exp_start[c] = '0; exp_stop[c] = '0; exp_busy[c] = 1'b0; exp_done[c] = 1'b0;
    end
    ln = (len > int'(DEPTH)) ? int'(DEPTH) : len;
    if (ln == 0) return t0 + 1;
    t = t0;
    pass = 0;
    while (((loops == 0) ? (t <= abort_at) : (pass < loops)) && t < LIM) begin
      for (int e = 0; e < ln; e++) begin
        fire = t + 1 + tbl_delay[e];
        if (fire >= LIM) break;
        exp_start[fire] = exp_start[fire] | tbl_mask[e];
        w = fire;
        if (tbl_wait[e]) begin
          w = fire + 2;
          while (w < LIM && ((rdy_wave[w] & tbl_mask[e]) != tbl_mask[e])) w++;
        end
        t = w;
      end
      pass++;
    end
    for (int c = t0 + 1; c <= t && c < LOGN; c++) exp_busy[c] = 1'b1;
    if (abort_at > t0 && abort_at <= t) begin
      fired = '0;
      for (int c = t0 + 1; c <= abort_at; c++) fired = fired | exp_start[c];
      for (int c = abort_at + 1; c < LOGN; c++) begin
        exp_start[c] = '0; exp_busy[c] = 1'b0;
      end
      exp_stop[abort_at + 1] = fired;
      return abort_at + 1;
    end
    exp_done[t + 1] = 1'b1;
    return t + 1;
  endfunction

  task automatic step;
    @(posedge clk_i); #1;
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) step();
  endtask

  task automatic clear_mirror;
    for (int i = 0; i < int'(DEPTH); i++) begin
      tbl_mask[i] = '0; tbl_delay[i] = 0; tbl_wait[i] = 1'b0;
    end
  endtask

  task automatic write_entry(input int idx, input logic [NP-1:0] m, input int d,
                             input bit w, input bit applied);
    cfg_we_i = 1'b1; cfg_idx_i = IW'(idx); cfg_mask_i = m;
    cfg_delay_i = DW'(d); cfg_wait_i = w;
    step();
    cfg_we_i = 1'b0;
    if (applied) begin
      tbl_mask[idx] = m; tbl_delay[idx] = d; tbl_wait[idx] = w;
    end
  endtask

  // Drives go for one cycle; t is the cycle in which go is sampled
  task automatic launch(input int len, input int loops, output int t);
    num_entries_i = (IW+1)'(len); loops_i = 8'(loops); go_i = 1'b1; t = cyc;
    step();
    go_i = 1'b0;
  endtask

  task automatic pulse_abort(input int a);
    goto_cycle(a);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk_i);
    #1;
    n_tests++; if (start_o !== '0) begin n_fail++; $display("FAIL reset_start got=%b exp=0000", start_o); end
    n_tests++; if (stop_o !== '0) begin n_fail++; $display("FAIL reset_stop got=%b exp=0000", stop_o); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_tests++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_o); end
    n_tests++; if (cur_idx_o !== '0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", cur_idx_o); end
    rst_i = 1'b0;
    clear_mirror();
    step();
  endtask

  task automatic test_basic;
    int t, te;
    write_entry(0, 4'b0001, 3, 1'b0, 1'b1);
    write_entry(1, 4'b0110, 0, 1'b0, 1'b1);
    launch(2, 1, t);
    te = model_run(t, 2, 1, -1);
    goto_cycle(te + 5);
    n_tests++; if (log_start[t+4] !== 4'b0001) begin n_fail++; $display("FAIL basic_first got=%b exp=0001", log_start[t+4]); end
    n_tests++; if (log_start[t+5] !== 4'b0110) begin n_fail++; $display("FAIL basic_second got=%b exp=0110", log_start[t+5]); end
    n_tests++; if (log_done[t+6] !== 1'b1 || log_busy[t+6] !== 1'b0) begin n_fail++; $display("FAIL basic_done got done=%b busy=%b exp done=1 busy=0", log_done[t+6], log_busy[t+6]); end
    for (int c = t; c <= te + 3; c++) begin
      n_tests++;
      if ({log_start[c], log_stop[c], log_busy[c], log_done[c]} !== {exp_start[c], exp_stop[c], exp_busy[c], exp_done[c]}) begin
        n_fail++;
        $display("FAIL basic cyc=%0d got s=%b p=%b b=%b d=%b exp s=%b p=%b b=%b d=%b", c - t,
                 log_start[c], log_stop[c], log_busy[c], log_done[c], exp_start[c], exp_stop[c], exp_busy[c], exp_done[c]);
      end
    end
  endtask

  task automatic test_wait_ready;
    int t, te, f;
    bit quiet;
    write_entry(0, 4'b0001, 0, 1'b1, 1'b1);
    write_entry(1, 4'b0010, 2, 1'b0, 1'b1);
    launch(2, 1, t);
    f = t + 1;
    for (int c = f + 1; c <= f + 20; c++) rdy_wave[c] = 4'b1110;
    te = model_run(t, 2, 1, -1);
    goto_cycle(te + 5);
    quiet = 1'b1;
    for (int c = f + 1; c <= f + 23; c++) if (log_start[c] !== '0) quiet = 1'b0;
    n_tests++; if (!quiet) begin n_fail++; $display("FAIL wait_quiet got=start_during_wait exp=no_start"); end
    n_tests++; if (log_start[f+24] !== 4'b0010) begin n_fail++; $display("FAIL wait_release got=%b exp=0010", log_start[f+24]); end
    for (int c = t; c <= te + 3; c++) begin
      n_tests++;
      if ({log_start[c], log_stop[c], log_busy[c], log_done[c]} !== {exp_start[c], exp_stop[c], exp_busy[c], exp_done[c]}) begin
        n_fail++;
        $display("FAIL wait cyc=%0d got s=%b p=%b b=%b d=%b exp s=%b p=%b b=%b d=%b", c - t,
                 log_start[c], log_stop[c], log_busy[c], log_done[c], exp_start[c], exp_stop[c], exp_busy[c], exp_done[c]);
      end
    end
    for (int c = 0; c < LOGN; c++) rdy_wave[c] = '1;
  endtask

  task automatic test_loops;
    int t, te;
    write_entry(0, 4'b1000, 1, 1'b0, 1'b1);
    launch(1, 3, t);
    te = model_run(t, 1, 3, -1);
    goto_cycle(te + 5);
    n_tests++; if (log_start[t+6] !== 4'b1000) begin n_fail++; $display("FAIL loops_third got=%b exp=1000", log_start[t+6]); end
    n_tests++; if (log_done[t+7] !== 1'b1) begin n_fail++; $display("FAIL loops_done got=%b exp=1", log_done[t+7]); end
    for (int c = t; c <= te + 3; c++) begin
      n_tests++;
      if ({log_start[c], log_stop[c], log_busy[c], log_done[c]} !== {exp_start[c], exp_stop[c], exp_busy[c], exp_done[c]}) begin
        n_fail++;
        $display("FAIL loops cyc=%0d got s=%b p=%b b=%b d=%b exp s=%b p=%b b=%b d=%b", c - t,
                 log_start[c], log_stop[c], log_busy[c], log_done[c], exp_start[c], exp_stop[c], exp_busy[c], exp_done[c]);
      end
    end
    // Infinite looping stopped by abort
    launch(1, 0, t);
    te = model_run(t, 1, 0, t + 9);
    pulse_abort(t + 9);
    goto_cycle(te + 5);
    n_tests++; if (log_stop[t+10] !== 4'b1000) begin n_fail++; $display("FAIL inf_stop got=%b exp=1000", log_stop[t+10]); end
    for (int c = t; c <= te + 3; c++) begin
      n_tests++;
      if ({log_start[c], log_stop[c], log_busy[c], log_done[c]} !== {exp_start[c], exp_stop[c], exp_busy[c], exp_done[c]}) begin
        n_fail++;
        $display("FAIL inf cyc=%0d got s=%b p=%b b=%b d=%b exp s=%b p=%b b=%b d=%b", c - t,
                 log_start[c], log_stop[c], log_busy[c], log_done[c], exp_start[c], exp_stop[c], exp_busy[c], exp_done[c]);
      end
    end
  endtask

  task automatic test_abort;
    int t, te;
    bit seen;
    write_entry(0, 4'b0011, 0, 1'b0, 1'b1);
    write_entry(1, 4'b0100, 10, 1'b0, 1'b1);
    launch(2, 1, t);
    te = model_run(t, 2, 1, t + 5);
    pulse_abort(t + 5);
    goto_cycle(t + 20);
    n_tests++; if (log_stop[t+6] !== 4'b0011 || log_busy[t+6] !== 1'b0) begin n_fail++; $display("FAIL abort_stop got stop=%b busy=%b exp stop=0011 busy=0", log_stop[t+6], log_busy[t+6]); end
    seen = 1'b0;
    for (int c = t + 6; c < t + 20; c++) if (log_start[c] !== '0 || log_done[c] !== 1'b0) seen = 1'b1;
    n_tests++; if (seen) begin n_fail++; $display("FAIL abort_after got=activity exp=none"); end
    for (int c = t; c <= te + 3; c++) begin
      n_tests++;
      if ({log_start[c], log_stop[c], log_busy[c], log_done[c]} !== {exp_start[c], exp_stop[c], exp_busy[c], exp_done[c]}) begin
        n_fail++;
        $display("FAIL abort cyc=%0d got s=%b p=%b b=%b d=%b exp s=%b p=%b b=%b d=%b", c - t,
                 log_start[c], log_stop[c], log_busy[c], log_done[c], exp_start[c], exp_stop[c], exp_busy[c], exp_done[c]);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int t, te;
    write_entry(0, 4'b0100, 3, 1'b0, 1'b1);
    write_entry(1, 4'b1000, 2, 1'b0, 1'b1);
    for (int pass = 0; pass < 2; pass++) begin
      launch(2, 1, t);
      te = model_run(t, 2, 1, -1);
      if (pass == 0) begin
        write_entry(0, 4'b1111, 0, 1'b1, 1'b0);  // busy: must not land
        go_i = 1'b1; num_entries_i = 4'd1;        // busy: must be ignored
        step();
        go_i = 1'b0;
      end
      goto_cycle(te + 5);
      for (int c = t; c <= te + 3; c++) begin
        n_tests++;
        if ({log_start[c], log_stop[c], log_busy[c], log_done[c]} !== {exp_start[c], exp_stop[c], exp_busy[c], exp_done[c]}) begin
          n_fail++;
          $display("FAIL busy_ign p%0d cyc=%0d got s=%b p=%b b=%b d=%b exp s=%b p=%b b=%b d=%b", pass, c - t,
                   log_start[c], log_stop[c], log_busy[c], log_done[c], exp_start[c], exp_stop[c], exp_busy[c], exp_done[c]);
        end
      end
    end
    // Zero-length run never starts
    launch(0, 1, t);
    goto_cycle(t + 6);
    for (int c = t; c <= t + 5; c++) begin
      n_tests++;
      if (log_busy[c] !== 1'b0 || log_start[c] !== '0) begin
        n_fail++;
        $display("FAIL len_zero cyc=%0d got busy=%b start=%b exp busy=0 start=0000", c - t, log_busy[c], log_start[c]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int t, te;
    write_entry(0, 4'b0101, 20, 1'b0, 1'b1);
    write_entry(1, 4'b1010, 0, 1'b0, 1'b1);
    launch(2, 1, t);
    goto_cycle(t + 5);
    #2;
    rst_i = 1'b1;
    #1;
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy_o); end
    n_tests++; if (start_o !== '0 || stop_o !== '0) begin n_fail++; $display("FAIL rstmid_strobes got start=%b stop=%b exp 0000", start_o, stop_o); end
    n_tests++; if (done_o !== 1'b0 || cur_idx_o !== '0) begin n_fail++; $display("FAIL rstmid_status got done=%b idx=%0d exp 0", done_o, cur_idx_o); end
    step();
    rst_i = 1'b0;
    clear_mirror();
    step();
    launch(2, 1, t);
    te = model_run(t, 2, 1, -1);
    goto_cycle(te + 5);
    n_tests++; if (log_done[t+3] !== 1'b1) begin n_fail++; $display("FAIL rstmid_cleared_done got=%b exp=1", log_done[t+3]); end
    for (int c = t; c <= te + 3; c++) begin
      n_tests++;
      if ({log_start[c], log_stop[c], log_busy[c], log_done[c]} !== {exp_start[c], exp_stop[c], exp_busy[c], exp_done[c]}) begin
        n_fail++;
        $display("FAIL rstmid cyc=%0d got s=%b p=%b b=%b d=%b exp s=%b p=%b b=%b d=%b", c - t,
                 log_start[c], log_stop[c], log_busy[c], log_done[c], exp_start[c], exp_stop[c], exp_busy[c], exp_done[c]);
      end
    end
  endtask

  task automatic test_random;
    int t, te, len, loops, ab;
    for (int it = 0; it < 12; it++) begin
      for (int e = 0; e < int'(DEPTH); e++)
        write_entry(e, NP'($urandom), int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0), 1'b1);
      len   = int'($urandom_range(0, 10));
      loops = int'($urandom_range(1, 3));
      ab    = ($urandom_range(0, 2) == 0) ? -2 : int'($urandom_range(1, 40));
      launch(len, loops, t);
      for (int c = t + 2; c < t + 600 && c < LOGN; c++)
        for (int b = 0; b < int'(NP); b++) rdy_wave[c][b] = ($urandom_range(0, 3) != 0);
      te = model_run(t, len, loops, (ab < 0) ? -1 : t + ab);
      if (ab >= 0) pulse_abort(t + ab);
      goto_cycle(((te > t + ab) ? te : t + ab) + 5);
      for (int c = t; c <= te + 3; c++) begin
        n_tests++;
        if ({log_start[c], log_stop[c], log_busy[c], log_done[c]} !== {exp_start[c], exp_stop[c], exp_busy[c], exp_done[c]}) begin
          n_fail++;
          $display("FAIL rand it=%0d cyc=%0d got s=%b p=%b b=%b d=%b exp s=%b p=%b b=%b d=%b", it, c - t,
                   log_start[c], log_stop[c], log_busy[c], log_done[c], exp_start[c], exp_stop[c], exp_busy[c], exp_done[c]);
        end
      end
      for (int c = 0; c < LOGN; c++) rdy_wave[c] = '1;
    end
  endtask

  initial begin
    for (int c = 0; c < LOGN; c++) rdy_wave[c] = '1;
    clear_mirror();
    test_reset();
    test_basic();
    test_wait_ready();
    test_loops();
    test_abort();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(10 * (LOGN - 16));
    $display("FAIL watchdog got=cycle_limit exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
